// File: rtl/bus_datapath_pkg.sv
// Shared definitions for the parametrised single-bus datapath:
// ALU operation codes, source/destination index offsets (relative to
// NUM_GPR) and the memory-read FSM state type.
package bus_datapath_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOT  = 4'd5;
  localparam logic [3:0] ALU_NEG  = 4'd6;
  localparam logic [3:0] ALU_SHL  = 4'd7;
  localparam logic [3:0] ALU_SHR  = 4'd8;
  localparam logic [3:0] ALU_SHRA = 4'd9;
  localparam logic [3:0] ALU_ROL  = 4'd10;
  localparam logic [3:0] ALU_ROR  = 4'd11;
  localparam logic [3:0] ALU_MUL  = 4'd12;
  localparam logic [3:0] ALU_MULS = 4'd13;
  localparam logic [3:0] ALU_PASS = 4'd14;
  localparam logic [3:0] ALU_ZERO = 4'd15;

  // Bus sources above the GPRs (add NUM_GPR for the src_oe bit index)
  localparam int SRC_HI  = 0;
  localparam int SRC_LO  = 1;
  localparam int SRC_ZHI = 2;
  localparam int SRC_ZLO = 3;
  localparam int SRC_PC  = 4;
  localparam int SRC_MDR = 5;
  localparam int NUM_SRC_SPECIAL = 6;

  // Load destinations above the GPRs (add NUM_GPR for the dst_in bit index)
  localparam int DST_HI  = 0;
  localparam int DST_LO  = 1;
  localparam int DST_PC  = 2;
  localparam int DST_IR  = 3;
  localparam int DST_MAR = 4;
  localparam int DST_MDR = 5;
  localparam int DST_Y   = 6;
  localparam int NUM_DST_SPECIAL = 7;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } mem_state_e;

endpackage

// File: rtl/bus_datapath_p_if.sv
// Control/memory-side signal bundle of bus_datapath_p.
// master = sequencer/memory side, slave = datapath.
interface bus_datapath_p_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_GPR = 16
);
  import bus_datapath_pkg::*;

  logic [NUM_GPR+NUM_SRC_SPECIAL-1:0] src_oe;
  logic [NUM_GPR+NUM_DST_SPECIAL-1:0] dst_in;
  logic                               z_in;
  logic [3:0]                         alu_op;
  logic                               mem_rd;
  logic                               mem_req;
  logic [WIDTH-1:0]                   mem_addr;
  logic                               mem_ack;
  logic [WIDTH-1:0]                   mdatain;
  logic                               err_clr;
  logic [WIDTH-1:0]                   bus_out;
  logic [WIDTH-1:0]                   ir_out;
  logic                               busy;
  logic                               rd_done;
  logic                               mem_err;
  logic                               bus_conflict;

  modport master (
    output src_oe, dst_in, z_in, alu_op, mem_rd, mem_ack, mdatain, err_clr,
    input  mem_req, mem_addr, bus_out, ir_out, busy, rd_done, mem_err, bus_conflict
  );

  modport slave (
    input  src_oe, dst_in, z_in, alu_op, mem_rd, mem_ack, mdatain, err_clr,
    output mem_req, mem_addr, bus_out, ir_out, busy, rd_done, mem_err, bus_conflict
  );

endinterface

// File: rtl/bus_alu_p.sv
// Combinational ALU: A = Y register, B = bus. Produces the full 2*WIDTH
// Z value; narrow operations zero-extend into the upper half.
module bus_alu_p
  import bus_datapath_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]         alu_op_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] z_o
);

  logic [WIDTH-1:0]          lo;
  logic [2*WIDTH-1:0]        wide;
  logic                      use_wide;
  logic [2*WIDTH-1:0]        ua, ub;
  logic signed [2*WIDTH-1:0] sa, sb;
  int unsigned               rot_amt;

  assign ua      = {{WIDTH{1'b0}}, a_i};
  assign ub      = {{WIDTH{1'b0}}, b_i};
  assign sa      = {{WIDTH{a_i[WIDTH-1]}}, a_i};
  assign sb      = {{WIDTH{b_i[WIDTH-1]}}, b_i};
  // Rotates wrap the 5-bit amount into the word width
  assign rot_amt = 32'(b_i[4:0]) % WIDTH;

  // Operation select; ADD/MUL/MULS drive the full width, others only ZLO
  always_comb begin
    lo       = '0;
    wide     = '0;
    use_wide = 1'b0;
    case (alu_op_i)
      ALU_ADD:  begin use_wide = 1'b1; wide = ua + ub; end
      ALU_SUB:  lo = a_i - b_i;
      ALU_AND:  lo = a_i & b_i;
      ALU_OR:   lo = a_i | b_i;
      ALU_XOR:  lo = a_i ^ b_i;
      ALU_NOT:  lo = ~b_i;
      ALU_NEG:  lo = -b_i;
      ALU_SHL:  lo = a_i << b_i[4:0];
      ALU_SHR:  lo = a_i >> b_i[4:0];
      ALU_SHRA: lo = $unsigned($signed(a_i) >>> b_i[4:0]);
      ALU_ROL:  lo = (a_i << rot_amt) | (a_i >> (WIDTH - rot_amt));
      ALU_ROR:  lo = (a_i >> rot_amt) | (a_i << (WIDTH - rot_amt));
      ALU_MUL:  begin use_wide = 1'b1; wide = ua * ub; end
      ALU_MULS: begin use_wide = 1'b1; wide = $unsigned(sa * sb); end
      ALU_PASS: lo = b_i;
      default:  lo = '0;
    endcase
    z_o = use_wide ? wide : {{WIDTH{1'b0}}, lo};
  end

endmodule

// File: rtl/bus_datapath_p.sv
// Single-bus register-transfer datapath with GPR file, special registers,
// memory-read handshake into MDR (with timeout) and sticky bus-conflict flag.
// Optional macro BUS_CONFLICT_TRAP_EN: when defined, every register and Z
// load is suppressed in a cycle where more than one bus source is enabled.
//
// state   | meaning
// IDLE    | no read outstanding; mem_rd starts one
// RD_WAIT | mem_req high, waiting for mem_ack or timeout
module bus_datapath_p
  import bus_datapath_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int NUM_GPR     = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input logic             clk,
  input logic             clr,
  bus_datapath_p_if.slave dp_if
);

  localparam int NSRC = NUM_GPR + NUM_SRC_SPECIAL;

  logic [WIDTH-1:0]   gpr_q [NUM_GPR];
  logic [WIDTH-1:0]   hi_q, lo_q, pc_q, ir_q, mar_q, mdr_q, y_q;
  logic [2*WIDTH-1:0] z_q, alu_z;
  logic [WIDTH-1:0]   src_val [NSRC];
  logic [WIDTH-1:0]   bus_val;
  logic               conflict, load_ok;
  mem_state_e         state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               rd_done_q, rd_done_d, mem_err_q, bus_conflict_q;
  logic               timeout, mem_cap, busy_d;

  // Source mux inputs in src_oe bit order
  always_comb begin
    for (int i = 0; i < NUM_GPR; i++) src_val[i] = gpr_q[i];
    src_val[NUM_GPR+SRC_HI]  = hi_q;
    src_val[NUM_GPR+SRC_LO]  = lo_q;
    src_val[NUM_GPR+SRC_ZHI] = z_q[2*WIDTH-1:WIDTH];
    src_val[NUM_GPR+SRC_ZLO] = z_q[WIDTH-1:0];
    src_val[NUM_GPR+SRC_PC]  = pc_q;
    src_val[NUM_GPR+SRC_MDR] = mdr_q;
  end

  // Bus: lowest-index enabled source wins; more than one enabled is a conflict
  always_comb begin
    bus_val = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (dp_if.src_oe[i]) bus_val = src_val[i];
    end
    conflict = |(dp_if.src_oe & (dp_if.src_oe - NSRC'(1)));
`ifdef BUS_CONFLICT_TRAP_EN
    load_ok  = ~conflict;
`else
    load_ok  = 1'b1;
`endif
  end

  bus_alu_p #(.WIDTH(WIDTH)) u_alu (
    .alu_op_i (dp_if.alu_op),
    .a_i      (y_q),
    .b_i      (bus_val),
    .z_o      (alu_z)
  );

  // Memory-read FSM next state and strobes
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_done_d = 1'b0;
    timeout   = 1'b0;
    mem_cap   = 1'b0;
    busy_d    = (state_q == RD_WAIT);
    case (state_q)
      IDLE: begin
        if (dp_if.mem_rd) begin
          state_d = RD_WAIT;
          cnt_d   = '0;
        end
      end
      RD_WAIT: begin
        if (dp_if.mem_ack) begin
          mem_cap   = 1'b1;
          rd_done_d = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q == 8'(MEM_TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, counter and sticky flags
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      rd_done_q      <= 1'b0;
      mem_err_q      <= 1'b0;
      bus_conflict_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      rd_done_q      <= rd_done_d;
      mem_err_q      <= timeout ? 1'b1 : (dp_if.err_clr ? 1'b0 : mem_err_q);
      bus_conflict_q <= conflict ? 1'b1 : (dp_if.err_clr ? 1'b0 : bus_conflict_q);
    end
  end

  // Register file and special registers; memory capture owns MDR while busy
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      z_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_GPR; i++) begin
        if (load_ok && dp_if.dst_in[i]) gpr_q[i] <= bus_val;
      end
      if (load_ok && dp_if.dst_in[NUM_GPR+DST_HI])  hi_q  <= bus_val;
      if (load_ok && dp_if.dst_in[NUM_GPR+DST_LO])  lo_q  <= bus_val;
      if (load_ok && dp_if.dst_in[NUM_GPR+DST_PC])  pc_q  <= bus_val;
      if (load_ok && dp_if.dst_in[NUM_GPR+DST_IR])  ir_q  <= bus_val;
      if (load_ok && dp_if.dst_in[NUM_GPR+DST_MAR]) mar_q <= bus_val;
      if (load_ok && dp_if.dst_in[NUM_GPR+DST_Y])   y_q   <= bus_val;
      if (mem_cap) begin
        mdr_q <= dp_if.mdatain;
      end else if (load_ok && !busy_d && dp_if.dst_in[NUM_GPR+DST_MDR]) begin
        mdr_q <= bus_val;
      end
      if (load_ok && dp_if.z_in) z_q <= alu_z;
    end
  end

  assign dp_if.bus_out      = bus_val;
  assign dp_if.ir_out       = ir_q;
  assign dp_if.mem_addr     = mar_q;
  assign dp_if.mem_req      = busy_d;
  assign dp_if.busy         = busy_d;
  assign dp_if.rd_done      = rd_done_q;
  assign dp_if.mem_err      = mem_err_q;
  assign dp_if.bus_conflict = bus_conflict_q;

endmodule
